// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges load-use and multi-cycle EX stalls, runs the divider
// start/done/cancel handshake with a timeout, and issues a registered flush + redirect PC.
module pipe_ctrl #(
  parameter int unsigned STALL_W    = 6,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id_i,
  input  logic               ex_mc_req_i,
  input  logic               mc_done_i,
  input  logic               flush_req_i,
  input  logic [31:0]        flush_pc_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [31:0]        new_pc_o,
  output logic               mc_start_o,
  output logic               mc_cancel_o,
  output logic               mc_timeout_o
);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] IDLE    = 2'd0;
  localparam logic [ST_W-1:0] MC_WAIT = 2'd1;
  localparam logic [ST_W-1:0] MC_DONE = 2'd2;

  localparam logic [STALL_W-1:0] STALL_NONE = '0;
  localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MC_TIMEOUT - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [31:0]      pc_q, pc_d;
  logic             start_q, start_d;
  logic             cancel_q, cancel_d;
  logic             timeout_q, timeout_d;

  logic kill_c;
  logic ex_stall_c;

  assign kill_c     = flush_req_i | flush_q;
  assign ex_stall_c = ((state_q == IDLE) & ex_mc_req_i & ~kill_c) | (state_q == MC_WAIT);

  // Hold vector is combinational so a stall takes effect in the request cycle.
  always_comb begin
    stall_o = STALL_NONE;
    if (!rst) begin
      stall_o = STALL_NONE;
    end else if (flush_q) begin
      stall_o = STALL_NONE;
    end else if (ex_stall_c) begin
      stall_o = STALL_EX;
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID;
    end
  end

  // Next-state and registered-output logic; a flush request overrides every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    cancel_d  = 1'b0;
    timeout_d = timeout_q;
    flush_d   = flush_req_i;
    pc_d      = flush_req_i ? flush_pc_i : pc_q;

    if (flush_req_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      cancel_d = (state_q == MC_WAIT);
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_mc_req_i && !flush_q) begin
            state_d = MC_WAIT;
            cnt_d   = '0;
            start_d = 1'b1;
          end
        end
        MC_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mc_done_i) begin
            state_d = MC_DONE;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = MC_DONE;
            timeout_d = 1'b1;
          end
        end
        MC_DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      pc_q      <= 32'h0;
      start_q   <= 1'b0;
      cancel_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      pc_q      <= pc_d;
      start_q   <= start_d;
      cancel_q  <= cancel_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush_o      = flush_q;
  assign new_pc_o     = pc_q;
  assign mc_start_o   = start_q;
  assign mc_cancel_o  = cancel_q;
  assign mc_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, multi-cycle op, flush, timeout and collisions.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id_i;
  logic        ex_mc_req_i;
  logic        mc_done_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_start_o;
  logic        mc_cancel_o;
  logic        mc_timeout_o;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STALL_W(6), .MC_TIMEOUT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .ex_mc_req_i  (ex_mc_req_i),
    .mc_done_i    (mc_done_i),
    .flush_req_i  (flush_req_i),
    .flush_pc_i   (flush_pc_i),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .new_pc_o     (new_pc_o),
    .mc_start_o   (mc_start_o),
    .mc_cancel_o  (mc_cancel_o),
    .mc_timeout_o (mc_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all outputs at once for the current cycle.
  task automatic chk_all(input string tag, input logic [5:0] stl, input logic fl,
                         input logic [31:0] pc, input logic st, input logic cn,
                         input logic to);
    #1;
    chk({tag, ".stall"},   32'(stall_o),      32'(stl));
    chk({tag, ".flush"},   32'(flush_o),      32'(fl));
    chk({tag, ".new_pc"},  new_pc_o,          pc);
    chk({tag, ".start"},   32'(mc_start_o),   32'(st));
    chk({tag, ".cancel"},  32'(mc_cancel_o),  32'(cn));
    chk({tag, ".timeout"}, 32'(mc_timeout_o), 32'(to));
  endtask

  initial begin
    rst = 1'b0; stallreq_id_i = 1'b1; ex_mc_req_i = 1'b0; mc_done_i = 1'b0;
    flush_req_i = 1'b0; flush_pc_i = 32'h0;
    #3;
    chk_all("reset", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    stallreq_id_i = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // Load-use stall
    tick(); stallreq_id_i = 1'b1;
    chk_all("lu_on", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); stallreq_id_i = 1'b0;
    chk_all("lu_off", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Multi-cycle op completing by mc_done_i; load-use is lower priority than EX stall
    ex_mc_req_i = 1'b1; stallreq_id_i = 1'b1;
    chk_all("mc_req", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); stallreq_id_i = 1'b0;
    chk_all("mc_start", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); mc_done_i = 1'b1;
    chk_all("mc_wait", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); mc_done_i = 1'b0;
    chk_all("mc_done", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); ex_mc_req_i = 1'b0;
    chk_all("mc_idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush mid-op cancels the unit
    ex_mc_req_i = 1'b1;
    tick(); ex_mc_req_i = 1'b0;
    chk_all("fl_start", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); flush_req_i = 1'b1; flush_pc_i = 32'hBFC00380;
    chk_all("fl_req", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); flush_req_i = 1'b0; ex_mc_req_i = 1'b1;
    chk_all("fl_out", 6'b000000, 1'b1, 32'hBFC00380, 1'b0, 1'b1, 1'b0);
    tick(); ex_mc_req_i = 1'b0;
    chk_all("fl_after", 6'b000000, 1'b0, 32'hBFC00380, 1'b0, 1'b0, 1'b0);

    // Back-to-back flushes; ex_mc_req_i ignored while killed
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_1000; ex_mc_req_i = 1'b1;
    chk_all("b2b_req", 6'b000000, 1'b0, 32'hBFC00380, 1'b0, 1'b0, 1'b0);
    tick(); flush_pc_i = 32'h0000_2000;
    chk_all("b2b_1", 6'b000000, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    tick(); flush_req_i = 1'b0; ex_mc_req_i = 1'b0;
    chk_all("b2b_2", 6'b000000, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("b2b_end", 6'b000000, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b0);

    // Timeout: 8 MC_WAIT cycles then forced MC_DONE
    ex_mc_req_i = 1'b1;
    tick(); ex_mc_req_i = 1'b0;
    chk_all("to_start", 6'b001111, 1'b0, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_all($sformatf("to_wait%0d", i), 6'b001111, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_all("to_done", 6'b000000, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1);
    tick(); mc_done_i = 1'b1;
    chk_all("to_idle", 6'b000000, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1);
    tick(); mc_done_i = 1'b0;
    chk_all("done_ign", 6'b000000, 1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1);

    // Flush and done collide: flush wins, cancel pulses
    ex_mc_req_i = 1'b1;
    tick(); ex_mc_req_i = 1'b0;
    tick(); flush_req_i = 1'b1; mc_done_i = 1'b1; flush_pc_i = 32'h0000_0100;
    tick(); flush_req_i = 1'b0; mc_done_i = 1'b0;
    chk_all("col_flush", 6'b000000, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
    tick(); ex_mc_req_i = 1'b1;
    chk_all("col_idle", 6'b001111, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);

    // Async reset in the middle of MC_WAIT
    tick(); ex_mc_req_i = 1'b0;
    chk_all("rst_start", 6'b001111, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b0;
    chk_all("rst_mid", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); rst = 1'b1;
    chk_all("rst_rel", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    ex_mc_req_i = 1'b1;
    tick(); ex_mc_req_i = 1'b0;
    chk_all("rst_restart", 6'b001111, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
